enemy_spawn_arbiter: RTL and testbench

Queues enemy-summon requests from the stage sequencer and assigns each to a free enemy slot in the fixed sprite/enemy-unit pool. Spawns are issued only on frame boundaries, at most one per frame, so the enemy datapath and the renderer never see a slot change mid-frame. The block sits between the sequencer's `Summon` output and the array of enemy units.

---
 rtl/spawn_pkg.sv | 13 +
 rtl/enemy_spawn_arbiter_if.sv | 15 +
 rtl/spawn_fifo.sv | 52 +++++
 rtl/enemy_spawn_arbiter.sv | 137 +++++++++++++
 tb/tb_enemy_spawn_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spawn_pkg.sv
// Shared types and constants for the enemy spawn arbiter.
package spawn_pkg;

    localparam int TYPE_W = 3;
    localparam logic [TYPE_W-1:0] SUMMON_NONE = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE
    } state_t;

endpackage

// File: rtl/enemy_spawn_arbiter_if.sv
// Spawn offer handshake between the arbiter (master) and the enemy-unit array (slave).
interface enemy_spawn_arbiter_if #(
    parameter int SLOT_W = 3
);
    import spawn_pkg::*;

    logic              spawn_valid;
    logic [SLOT_W-1:0] spawn_slot;
    logic [TYPE_W-1:0] spawn_type;
    logic              spawn_ack;

    modport master (output spawn_valid, spawn_slot, spawn_type, input spawn_ack);
    modport slave  (input spawn_valid, spawn_slot, spawn_type, output spawn_ack);

endinterface

// File: rtl/spawn_fifo.sv
// First-word fall-through request FIFO with synchronous flush.
module spawn_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/enemy_spawn_arbiter.sv
// Queues summon requests and grants one free enemy slot per frame tick.
// Define SPAWN_RR_EN for round-robin slot selection; default is lowest-index priority.
module enemy_spawn_arbiter
    import spawn_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int QDEPTH    = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [TYPE_W-1:0]         Summon,
    input  logic                      is_game,
    input  logic                      frame_tick,
    input  logic [NUM_SLOTS-1:0]      slot_free,
    enemy_spawn_arbiter_if.master     spawn,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      overflow
);

    localparam int CW = $clog2(QDEPTH) + 1;

    state_t               state_q, state_d;
    logic [NUM_SLOTS-1:0] rsv_q, rsv_d, elig;
    logic [SLOT_W-1:0]    slot_q, slot_d, sel_slot;
    logic [TYPE_W-1:0]    type_q, type_d, head;
    logic                 ovf_q, ovf_d, sel_found;
    logic                 push_req, push, ack_fire, full, empty;
    logic [CW-1:0]        cnt_after;

    assign push_req  = is_game && (Summon != SUMMON_NONE);
    assign ack_fire  = is_game && (state_q == S_ISSUE) && spawn.spawn_ack;
    assign push      = push_req && (!full || ack_fire);
    assign cnt_after = q_count + CW'(push) - CW'(ack_fire);
    assign elig      = slot_free & ~rsv_q;

    spawn_fifo #(.W(TYPE_W), .DEPTH(QDEPTH)) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .flush (!is_game),
        .push  (push),
        .pop   (ack_fire),
        .wdata (Summon),
        .rdata (head),
        .count (q_count),
        .full  (full),
        .empty (empty)
    );

`ifdef SPAWN_RR_EN
    logic [SLOT_W-1:0] last_slot_q;

    always_ff @(posedge Clk) begin
        if (Reset)         last_slot_q <= SLOT_W'(NUM_SLOTS - 1);
        else if (ack_fire) last_slot_q <= slot_q;
    end

    always_comb begin
        logic [SLOT_W-1:0] idx;
        idx       = '0;
        sel_slot  = '0;
        sel_found = 1'b0;
        // Index arithmetic wraps naturally because NUM_SLOTS is a power of two.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = last_slot_q + SLOT_W'(i + 1);
            if (!sel_found && elig[idx]) begin
                sel_slot  = idx;
                sel_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel_slot  = '0;
        sel_found = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_slot  = SLOT_W'(i);
                sel_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        type_d  = type_q;
        if (!is_game) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (push || q_count != '0) state_d = S_WAIT;
                S_WAIT: begin
                    if (frame_tick && !empty && sel_found) begin
                        slot_d  = sel_slot;
                        type_d  = head;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: if (spawn.spawn_ack) state_d = (cnt_after != '0) ? S_WAIT : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rsv_d = rsv_q & slot_free;
        if (ack_fire) rsv_d[slot_q] = 1'b1;
        if (!is_game) rsv_d = '0;
        ovf_d = ovf_q;
        if (!is_game) ovf_d = 1'b0;
        if (push_req && full && !ack_fire) ovf_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            type_q  <= '0;
            rsv_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            type_q  <= type_d;
            rsv_q   <= rsv_d;
            ovf_q   <= ovf_d;
        end
    end

    assign spawn.spawn_valid = (state_q == S_ISSUE);
    assign spawn.spawn_slot  = slot_q;
    assign spawn.spawn_type  = type_q;
    assign overflow          = ovf_q;

endmodule

// File: tb/tb_enemy_spawn_arbiter.sv
// Directed bench for enemy_spawn_arbiter; expected types queued at summon, checked at grant.
module tb_enemy_spawn_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] Summon;
    logic       is_game;
    logic       frame_tick;
    logic [7:0] slot_free;
    logic [2:0] q_count;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] sb[$];
    logic [7:0] rsv_m;
    int         last_exp;
    int         cur_slot;

    enemy_spawn_arbiter_if #(.SLOT_W(3)) sif ();

    enemy_spawn_arbiter #(.NUM_SLOTS(8), .QDEPTH(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Summon     (Summon),
        .is_game    (is_game),
        .frame_tick (frame_tick),
        .slot_free  (slot_free),
        .spawn      (sif.master),
        .q_count    (q_count),
        .overflow   (overflow)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] el);
`ifdef SPAWN_RR_EN
        for (int i = 1; i <= 8; i++) begin
            if (el[(last_exp + i) % 8]) return (last_exp + i) % 8;
        end
`else
        for (int i = 0; i < 8; i++) begin
            if (el[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic summon(input logic [2:0] t);
        Summon = t;
        step();
        Summon = 3'b000;
        sb.push_back(t);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic grant(input string tag);
        int n = 0;
        logic [2:0] et;
        while (sif.spawn_valid !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(sif.spawn_valid), 32'd1);
        et = (sb.size() > 0) ? sb.pop_front() : 3'b000;
        cur_slot = pick(slot_free & ~rsv_m);
        chk({tag, "_slot"}, 32'(sif.spawn_slot), 32'(cur_slot));
        chk({tag, "_type"}, 32'(sif.spawn_type), 32'(et));
    endtask

    task automatic ack(input string tag);
        sif.spawn_ack = 1'b1;
        step();
        sif.spawn_ack = 1'b0;
        rsv_m[cur_slot] = 1'b1;
        last_exp = cur_slot;
        chk({tag, "_drop"}, 32'(sif.spawn_valid), 32'd0);
    endtask

    task automatic release_slots(input logic [7:0] mask);
        slot_free = ~mask;
        step();
        slot_free = 8'hFF;
        rsv_m = rsv_m & ~mask;
    endtask

    initial begin
        Reset = 1'b1; Summon = 3'b000; is_game = 1'b0; frame_tick = 1'b0;
        slot_free = 8'hFF; sif.spawn_ack = 1'b0;
        rsv_m = 8'h00; last_exp = 7; cur_slot = 0;
        step(); step();
        Reset = 1'b0; is_game = 1'b1;
        chk("rst_valid", 32'(sif.spawn_valid), 32'd0);
        chk("rst_slot", 32'(sif.spawn_slot), 32'd0);
        chk("rst_type", 32'(sif.spawn_type), 32'd0);
        chk("rst_qcount", 32'(q_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // single spawn
        summon(3'd1);
        chk("enq_lat", 32'(q_count), 32'd1);
        repeat (5) step();
        tick();
        grant("single");
        ack("single");
        chk("single_q", 32'(q_count), 32'd0);

        // reservation, and a tick during an offer is not remembered
        summon(3'd2);
        summon(3'd3);
        chk("rsv_q2", 32'(q_count), 32'd2);
        tick();
        grant("rsv1");
        tick();
        ack("rsv1");
        step();
        chk("tick_ignored", 32'(sif.spawn_valid), 32'd0);
        chk("rsv_q1", 32'(q_count), 32'd1);
        release_slots(8'h03);
        tick();
        grant("rsv2");
        ack("rsv2");

        // overflow, then push alongside ack with the FIFO full
        for (int t = 1; t <= 5; t++) begin
            Summon = 3'(t);
            step();
            if (t <= 4) sb.push_back(3'(t));
        end
        Summon = 3'b000;
        chk("ovf_q", 32'(q_count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        tick();
        grant("ovf_g");
        Summon = 3'd6;
        sif.spawn_ack = 1'b1;
        step();
        Summon = 3'b000;
        sif.spawn_ack = 1'b0;
        rsv_m[cur_slot] = 1'b1;
        last_exp = cur_slot;
        sb.push_back(3'd6);
        chk("full_pushpop_q", 32'(q_count), 32'd4);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        repeat (4) begin
            tick();
            grant("drain");
            ack("drain");
        end
        chk("drain_q", 32'(q_count), 32'd0);

        // pool full
        slot_free = 8'h00;
        step();
        rsv_m = 8'h00;
        summon(3'd7);
        summon(3'd1);
        repeat (3) begin
            tick();
            chk("pool_full", 32'(sif.spawn_valid), 32'd0);
        end
        chk("pool_q", 32'(q_count), 32'd2);
        slot_free = 8'h10;
        tick();
        grant("pool4");
        ack("pool4");
        tick();
        chk("pool_rsv", 32'(sif.spawn_valid), 32'd0);
        slot_free = 8'hFF;
        tick();
        grant("pool_rel");
        ack("pool_rel");
        chk("pool_end_q", 32'(q_count), 32'd0);

        // ack without an offer is ignored
        summon(3'd4);
        sif.spawn_ack = 1'b1;
        step();
        sif.spawn_ack = 1'b0;
        chk("stray_ack_q", 32'(q_count), 32'd1);
        tick();
        grant("stray");
        ack("stray");

        // abort by leaving gameplay mid-offer
        for (int t = 1; t <= 5; t++) begin
            Summon = 3'(t);
            step();
        end
        Summon = 3'b000;
        sb.push_back(3'd1);
        chk("abort_ovf_pre", 32'(overflow), 32'd1);
        tick();
        grant("abort");
        is_game = 1'b0;
        step();
        chk("abort_valid", 32'(sif.spawn_valid), 32'd0);
        chk("abort_q", 32'(q_count), 32'd0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        is_game = 1'b1;
        sb.delete();
        rsv_m = 8'h00;

        // reset mid-offer
        summon(3'd2);
        tick();
        grant("rstmid");
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rstmid_valid", 32'(sif.spawn_valid), 32'd0);
        chk("rstmid_q", 32'(q_count), 32'd0);
        sb.delete();
        rsv_m = 8'h00;
        last_exp = 7;

        // nine sequential grants with all slots released between them
        for (int k = 0; k < 9; k++) begin
            summon(3'((k % 7) + 1));
            tick();
            grant("seq");
            ack("seq");
            release_slots(8'hFF);
        end
        chk("seq_q", 32'(q_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
